uart_word_loader: RTL and testbench

- Sits between the byte-level UART receiver and the second (loader) write port of processor RAM.
- Parses a framed byte stream: sync, start address, word count, big-endian 32-bit payload words, XOR checksum.
- Writes each assembled word to RAM via a single-cycle write strobe.
- Reports completion, checksum errors and inter-byte timeouts to the memory map.

---
 rtl/uart_word_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_word_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// Frame parser between the UART byte receiver and the loader write port of RAM:
// SYNC, 16-bit address, 16-bit word count, big-endian words, XOR checksum.
module uart_word_loader #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    CNT_HI  = 3'd3,
    CNT_LO  = 3'd4,
    DATA    = 3'd5,
    CHECK   = 3'd6
  } state_t;

  state_t                state, state_nx;
  logic [7:0]            hi_byte, hi_byte_nx;
  logic [15:0]           pair;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [15:0]           words_left, words_left_nx;
  logic [23:0]           word, word_nx;
  logic [1:0]            lane, lane_nx;
  logic [7:0]            csum, csum_nx;
  logic [TW-1:0]         tcnt, tcnt_nx;
  logic                  ram_we_nx, busy_nx, load_done_nx, load_err_nx;
  logic [ADDR_WIDTH-1:0] ram_addr_nx;
  logic [31:0]           ram_data_nx;

  // Next-state and next-output logic; every register holds unless a byte or timeout acts on it.
  always_comb begin
    state_nx      = state;
    hi_byte_nx    = hi_byte;
    addr_nx       = addr;
    words_left_nx = words_left;
    word_nx       = word;
    lane_nx       = lane;
    csum_nx       = csum;
    ram_we_nx     = 1'b0;
    ram_addr_nx   = ram_addr;
    ram_data_nx   = ram_data;
    load_done_nx  = 1'b0;
    load_err_nx   = load_err;
    pair          = {hi_byte, byte_data};
    if (state == IDLE || byte_valid) begin
      tcnt_nx = '0;
    end else begin
      tcnt_nx = tcnt + 1'b1;
    end

    if (state != IDLE && !byte_valid && tcnt == TW'(TIMEOUT - 1)) begin
      // Abandon the frame; any partially assembled word is simply never written.
      state_nx    = IDLE;
      lane_nx     = 2'd0;
      load_err_nx = 1'b1;
      tcnt_nx     = '0;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == SYNC_BYTE) begin
            state_nx    = ADDR_HI;
            load_err_nx = 1'b0;
            csum_nx     = 8'd0;
          end else begin
            state_nx = IDLE;
          end
        end
        ADDR_HI: begin
          hi_byte_nx = byte_data;
          csum_nx    = csum ^ byte_data;
          state_nx   = ADDR_LO;
        end
        ADDR_LO: begin
          addr_nx  = pair[ADDR_WIDTH-1:0];
          csum_nx  = csum ^ byte_data;
          state_nx = CNT_HI;
        end
        CNT_HI: begin
          hi_byte_nx = byte_data;
          csum_nx    = csum ^ byte_data;
          state_nx   = CNT_LO;
        end
        CNT_LO: begin
          words_left_nx = pair;
          csum_nx       = csum ^ byte_data;
          lane_nx       = 2'd0;
          if (pair == 16'd0) begin
            state_nx = CHECK;
          end else begin
            state_nx = DATA;
          end
        end
        DATA: begin
          csum_nx = csum ^ byte_data;
          if (lane == 2'd3) begin
            ram_we_nx     = 1'b1;
            ram_addr_nx   = addr;
            ram_data_nx   = {word, byte_data};
            addr_nx       = addr + 1'b1;
            words_left_nx = words_left - 16'd1;
            lane_nx       = 2'd0;
            if (words_left == 16'd1) begin
              state_nx = CHECK;
            end else begin
              state_nx = DATA;
            end
          end else begin
            word_nx = {word[15:0], byte_data};
            lane_nx = lane + 2'd1;
          end
        end
        CHECK: begin
          if (byte_data == csum) begin
            load_done_nx = 1'b1;
          end else begin
            load_err_nx = 1'b1;
          end
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end else begin
      state_nx = state;
    end
    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hi_byte    <= 8'd0;
      addr       <= '0;
      words_left <= 16'd0;
      word       <= 24'd0;
      lane       <= 2'd0;
      csum       <= 8'd0;
      tcnt       <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= 32'd0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      hi_byte    <= hi_byte_nx;
      addr       <= addr_nx;
      words_left <= words_left_nx;
      word       <= word_nx;
      lane       <= lane_nx;
      csum       <= csum_nx;
      tcnt       <= tcnt_nx;
      ram_we     <= ram_we_nx;
      ram_addr   <= ram_addr_nx;
      ram_data   <= ram_data_nx;
      busy       <= busy_nx;
      load_done  <= load_done_nx;
      load_err   <= load_err_nx;
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: frames are built from a byte-level model,
// expected RAM writes and done pulses are queued and popped by an independent monitor.
module tb_uart_word_loader;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int bv_edge = -10;

  logic [43:0] wq[$];
  bit          dq[$];
  logic [31:0] pay[$];
  logic [7:0]  fb[$];

  uart_word_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (byte_valid) bv_edge <= cyc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we) begin
        chk("we_latency", cyc, bv_edge + 1);
        chk("write_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          logic [43:0] e;
          e = wq.pop_front();
          chk("ram_addr", ram_addr, e[43:32]);
          chk("ram_data", ram_data, e[31:0]);
        end
      end
      if (load_done) begin
        chk("done_expected", dq.size() > 0, 1);
        if (dq.size() > 0) void'(dq.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  // Reference model: builds the frame bytes, XOR checksum and expected writes from pay[].
  task automatic run_frame(input logic [15:0] a, input bit bad);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [11:0] ea;
    n = 16'(pay.size());
    fb.delete();
    fb.push_back(a[15:8]);
    fb.push_back(a[7:0]);
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    foreach (pay[i]) begin
      fb.push_back(pay[i][31:24]);
      fb.push_back(pay[i][23:16]);
      fb.push_back(pay[i][15:8]);
      fb.push_back(pay[i][7:0]);
      ea = a[11:0] + 12'(i);
      wq.push_back({ea, pay[i]});
    end
    cs = 8'd0;
    foreach (fb[i]) cs = cs ^ fb[i];
    if (!bad) dq.push_back(1'b1);
    send_byte(8'hA5);
    chk("sync_clears_err", load_err, 0);
    chk("busy_in_frame", busy, 1);
    foreach (fb[i]) send_byte(fb[i]);
    send_byte(bad ? cs + 8'd1 : cs);
    repeat (2) @(negedge clk);
    chk("err_flag", load_err, bad);
    chk("busy_after", busy, 0);
    chk("writes_drained", wq.size(), 0);
    chk("done_drained", dq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ram_we, ram_addr, ram_data, busy, load_done, load_err}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", {ram_we, ram_addr, ram_data, busy, load_done, load_err}, 0);

    pay.delete(); pay.push_back(32'hDEADBEEF);
    run_frame(16'h0010, 1'b0);
    run_frame(16'h0010, 1'b1);

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    chk("garbage_keeps_err", load_err, 1);
    chk("garbage_not_busy", busy, 0);

    pay.delete(); pay.push_back(32'h11111111); pay.push_back(32'h22222222);
    run_frame(16'h0FFF, 1'b0);
    pay.delete();
    run_frame(16'h1234, 1'b0);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    repeat (50) @(negedge clk);
    chk("busy_before_timeout", busy, 1);
    chk("no_err_before_timeout", load_err, 0);
    repeat (60) @(negedge clk);
    chk("timeout_err", load_err, 1);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_write", wq.size(), 0);
    pay.delete(); pay.push_back(32'hCAFEF00D);
    run_frame(16'h0020, 1'b0);

    for (int k = 0; k < 8; k++) begin
      pay.delete();
      for (int j = 0; j < int'($urandom_range(4, 0)); j++) pay.push_back($urandom);
      run_frame(16'($urandom), $urandom_range(3, 0) == 0);
    end

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h23);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    chk("busy_mid_data", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {ram_we, ram_addr, ram_data, busy, load_done, load_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_byte(8'h03); send_byte(8'h04);
    repeat (3) @(negedge clk);
    chk("after_reset_outputs", {ram_we, ram_addr, ram_data, busy, load_done, load_err}, 0);
    pay.delete(); pay.push_back(32'h0BADF00D);
    run_frame(16'h0ABC, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
